// File: rtl/fifo_sync_depth8_if.sv
// Producer/consumer-facing bundle of the 8-entry FIFO: write side, pop side and status flags.
// master = the side that pushes/pops; slave = the FIFO itself.
interface fifo_sync_depth8_if #(
  parameter int BW = 4
);
  logic [BW-1:0] in;
  logic          wr;
  logic          rd;
  logic [BW-1:0] out;
  logic          o_full;
  logic          o_empty;
  logic [3:0]    o_count;
  logic          o_ovf;
  logic          o_udf;

  modport master (
    output in, wr, rd,
    input  out, o_full, o_empty, o_count, o_ovf, o_udf
  );

  modport slave (
    input  in, wr, rd,
    output out, o_full, o_empty, o_count, o_ovf, o_udf
  );
endinterface

// File: rtl/fifo_sync_depth8.sv
// 8-deep first-word-fall-through FIFO; a written word is visible on out one edge later, pops take effect at the edge.
// Writes at full and reads at empty are dropped; sticky error flags exist only with FIFO_ERR_FLAG_EN.
module fifo_mux_8_1 #(
  parameter int BW = 4
) (
  input  logic [BW-1:0] d_i [8],
  input  logic [2:0]    sel_i,
  output logic [BW-1:0] y_o
);
  logic [BW-1:0] lvl1 [4];
  logic [BW-1:0] lvl2 [2];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lvl1[i] = sel_i[0] ? d_i[2*i+1] : d_i[2*i];
    end
    for (int i = 0; i < 2; i++) begin
      lvl2[i] = sel_i[1] ? lvl1[2*i+1] : lvl1[2*i];
    end
    y_o = sel_i[2] ? lvl2[1] : lvl2[0];
  end
endmodule

module fifo_sync_depth8 #(
  parameter int BW = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  fifo_sync_depth8_if.slave fif
);
  logic [3:0]    wr_ptr_q, wr_ptr_d;
  logic [3:0]    rd_ptr_q, rd_ptr_d;
  logic [BW-1:0] mem_q [8];
  logic [BW-1:0] head_dat;
  logic          full;
  logic          empty;
  logic          wr_acc;
  logic          rd_acc;

  // Bit 3 of each pointer is the lap bit: equal low bits mean empty on the same lap, full on different laps.
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[2:0] == rd_ptr_q[2:0]) && (wr_ptr_q[3] != rd_ptr_q[3]);
  assign wr_acc = fif.wr && !full;
  assign rd_acc = fif.rd && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 4'd1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 4'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= 4'd0;
      rd_ptr_q <= 4'd0;
      for (int i = 0; i < 8; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (wr_acc) mem_q[wr_ptr_q[2:0]] <= fif.in;
    end
  end

  fifo_mux_8_1 #(.BW(BW)) u_rd_mux (
    .d_i   (mem_q),
    .sel_i (rd_ptr_q[2:0]),
    .y_o   (head_dat)
  );

  assign fif.out     = head_dat;
  assign fif.o_full  = full;
  assign fif.o_empty = empty;
  assign fif.o_count = wr_ptr_q - rd_ptr_q;

`ifdef FIFO_ERR_FLAG_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  always_comb begin
    ovf_d = ovf_q || (fif.wr && full);
    udf_d = udf_q || (fif.rd && empty);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign fif.o_ovf = ovf_q;
  assign fif.o_udf = udf_q;
`else
  assign fif.o_ovf = 1'b0;
  assign fif.o_udf = 1'b0;
`endif
endmodule
